// File: rtl/traffic_phase_scheduler.sv
// Two-road signal phase sequencer: G1-Y1-AR-G2-Y2-AR with pedestrian service and gap-out.
// Optional flashing-red mode is compiled in when FLASH_MODE_EN is defined.
module traffic_phase_scheduler #(
  parameter int GREEN_TIME  = 5,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1,
  parameter int MIN_GREEN   = 2,
  parameter int TIMER_W     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       TICK,
  input  logic       PED_REQ1,
  input  logic       PED_REQ2,
`ifdef FLASH_MODE_EN
  input  logic       FLASH,
`endif
  output logic       G1,
  output logic       Y1,
  output logic       R1,
  output logic       G2,
  output logic       Y2,
  output logic       R2,
  output logic       WALK1,
  output logic       WALK2,
  output logic       PED_ACK1,
  output logic       PED_ACK2,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    S_AR_A  = 3'd0,
    S_G1    = 3'd1,
    S_Y1    = 3'd2,
    S_AR_B  = 3'd3,
    S_G2    = 3'd4,
    S_Y2    = 3'd5,
    S_FLASH = 3'd6,
    S_BAD   = 3'd7
  } state_t;

  state_t             r_state, w_next;
  logic [TIMER_W-1:0] r_cnt, w_cnt_next, w_last;
  logic               r_pend1, r_pend2;
  logic               r_walk1, r_walk2;
  logic               r_ack1, r_ack2;
  logic [5:0]         r_lamp, w_lamp;
  logic               w_gap, w_end;
  logic               w_acc1, w_acc2;
  logic               w_walk1, w_walk2;
`ifdef FLASH_MODE_EN
  logic               r_flash_r, w_flash_r;
`endif

  // Last count of the current phase and whether a waiting cross street may cut green short
  always_comb begin
    w_last = TIMER_W'(ALLRED_TIME - 1);
    w_gap  = 1'b0;
    case (r_state)
      S_G1: begin
        w_last = TIMER_W'(GREEN_TIME - 1);
        w_gap  = r_pend2 && (r_cnt >= TIMER_W'(MIN_GREEN - 1));
      end
      S_G2: begin
        w_last = TIMER_W'(GREEN_TIME - 1);
        w_gap  = r_pend1 && (r_cnt >= TIMER_W'(MIN_GREEN - 1));
      end
      S_Y1, S_Y2: w_last = TIMER_W'(YELLOW_TIME - 1);
      default:    w_last = TIMER_W'(ALLRED_TIME - 1);
    endcase
    w_end = (r_cnt == w_last) || w_gap;
  end

  // Next state and phase counter; only TICK advances time, illegal codes recover to AR_A
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
`ifdef FLASH_MODE_EN
    w_flash_r  = r_flash_r;
`endif
    case (r_state)
      S_AR_A, S_G1, S_Y1, S_AR_B, S_G2, S_Y2: begin
        if (TICK) begin
          if (w_end) begin
            w_cnt_next = '0;
            case (r_state)
              S_AR_A:  w_next = S_G1;
              S_G1:    w_next = S_Y1;
              S_Y1:    w_next = S_AR_B;
              S_AR_B:  w_next = S_G2;
              S_G2:    w_next = S_Y2;
              default: w_next = S_AR_A;
            endcase
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end
      end
`ifdef FLASH_MODE_EN
      S_FLASH: begin
        if (TICK && !FLASH) begin
          w_next     = S_AR_A;
          w_cnt_next = '0;
        end
      end
`endif
      default: begin
        w_next     = S_AR_A;
        w_cnt_next = '0;
      end
    endcase
`ifdef FLASH_MODE_EN
    if (TICK && FLASH) begin
      w_next     = S_FLASH;
      w_cnt_next = '0;
      w_flash_r  = (r_state == S_FLASH) ? ~r_flash_r : 1'b1;
    end
`endif
  end

  // Pedestrian acceptance on green entry and lamp decode of the upcoming state
  always_comb begin
    w_acc1  = (w_next == S_G1) && (r_state != S_G1)
              && (r_pend1 || PED_REQ1);
    w_acc2  = (w_next == S_G2) && (r_state != S_G2)
              && (r_pend2 || PED_REQ2);
    w_walk1 = (w_next == S_G1)
              && ((r_state == S_G1) ? r_walk1 : w_acc1);
    w_walk2 = (w_next == S_G2)
              && ((r_state == S_G2) ? r_walk2 : w_acc2);
    w_lamp  = 6'b001_001;
    case (w_next)
      S_G1:    w_lamp = 6'b100_001;
      S_Y1:    w_lamp = 6'b010_001;
      S_G2:    w_lamp = 6'b001_100;
      S_Y2:    w_lamp = 6'b001_010;
`ifdef FLASH_MODE_EN
      S_FLASH: w_lamp = {2'b00, w_flash_r, 2'b00, w_flash_r};
`endif
      default: w_lamp = 6'b001_001;
    endcase
  end

  // State, counter, pending latches and registered outputs
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= S_AR_A;
      r_cnt   <= '0;
      r_pend1 <= 1'b0;
      r_pend2 <= 1'b0;
      r_walk1 <= 1'b0;
      r_walk2 <= 1'b0;
      r_ack1  <= 1'b0;
      r_ack2  <= 1'b0;
      r_lamp  <= 6'b001_001;
`ifdef FLASH_MODE_EN
      r_flash_r <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_pend1 <= w_acc1 ? 1'b0 : (r_pend1 | PED_REQ1);
      r_pend2 <= w_acc2 ? 1'b0 : (r_pend2 | PED_REQ2);
      r_walk1 <= w_walk1;
      r_walk2 <= w_walk2;
      r_ack1  <= w_acc1;
      r_ack2  <= w_acc2;
      r_lamp  <= w_lamp;
`ifdef FLASH_MODE_EN
      r_flash_r <= w_flash_r;
`endif
    end
  end

  assign {G1, Y1, R1, G2, Y2, R2} = r_lamp;
  assign WALK1    = r_walk1;
  assign WALK2    = r_walk2;
  assign PED_ACK1 = r_ack1;
  assign PED_ACK2 = r_ack2;
  assign PHASE    = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: vector table through a scoreboard queue,
// plus hand sequences for async reset, slow TICK and (FLASH_MODE_EN) flashing red.
module tb_traffic_phase_scheduler;

  logic       CLK = 1'b0;
  logic       RESET, TICK, PED_REQ1, PED_REQ2;
`ifdef FLASH_MODE_EN
  logic       FLASH;
`endif
  logic       G1, Y1, R1, G2, Y2, R2;
  logic       WALK1, WALK2, PED_ACK1, PED_ACK2;
  logic [2:0] PHASE;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit       tick;
    bit       req1;
    bit       req2;
    bit [2:0] ph;
    bit [3:0] ped;
  } vec_t;

  typedef struct {
    bit [2:0] ph;
    bit [5:0] lamps;
    bit [3:0] ped;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   seq[18];

  traffic_phase_scheduler dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK),
    .PED_REQ1(PED_REQ1), .PED_REQ2(PED_REQ2),
`ifdef FLASH_MODE_EN
    .FLASH(FLASH),
`endif
    .G1(G1), .Y1(Y1), .R1(R1), .G2(G2), .Y2(Y2), .R2(R2),
    .WALK1(WALK1), .WALK2(WALK2),
    .PED_ACK1(PED_ACK1), .PED_ACK2(PED_ACK2),
    .PHASE(PHASE)
  );

  always #5 CLK = ~CLK;

  function automatic bit [5:0] lamps_for(input bit [2:0] ph);
    case (ph)
      3'd1:    return 6'b100_001;
      3'd2:    return 6'b010_001;
      3'd4:    return 6'b001_100;
      3'd5:    return 6'b001_010;
      default: return 6'b001_001;
    endcase
  endfunction

  function automatic logic [12:0] obs();
    return {PHASE, G1, Y1, R1, G2, Y2, R2, WALK1, WALK2, PED_ACK1, PED_ACK2};
  endfunction

  task automatic check(input string name, input logic [12:0] act,
                       input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ped = {walk1, walk2, ack1, ack2}
  task automatic addn(input int n, input bit t, input bit r1, input bit r2,
                      input bit [2:0] ph, input bit [3:0] ped);
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.tick = t;
      v.req1 = r1;
      v.req2 = r2;
      v.ph   = ph;
      v.ped  = ped;
      vecs.push_back(v);
    end
  endtask

  initial begin
    int ph_l[6]  = '{1, 2, 3, 4, 5, 0};
    int dur_l[6] = '{5, 3, 1, 5, 3, 1};
    int idx;
    bit found;
    exp_t e;

    idx = 0;
    for (int p = 0; p < 6; p++)
      for (int d = 0; d < dur_l[p]; d++) begin
        seq[idx] = ph_l[p];
        idx++;
      end

    RESET = 1'b1; TICK = 1'b0; PED_REQ1 = 1'b0; PED_REQ2 = 1'b0;
`ifdef FLASH_MODE_EN
    FLASH = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", obs(), {3'd0, 6'b001_001, 4'b0});
    TICK = 1'b1;
    @(posedge CLK); #1;
    check("tick_in_reset", obs(), {3'd0, 6'b001_001, 4'b0});
    RESET = 1'b0;
    TICK  = 1'b0;

    // no ticks: hold; then one plain period, no requests
    addn(2, 0, 0, 0, 0, 4'b0000);
    addn(5, 1, 0, 0, 1, 4'b0000);
    addn(3, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 0, 0, 3, 4'b0000);
    addn(5, 1, 0, 0, 4, 4'b0000);
    addn(3, 1, 0, 0, 5, 4'b0000);
    addn(1, 1, 0, 0, 0, 4'b0000);
    addn(5, 1, 0, 0, 1, 4'b0000);
    // road 2 request in first G1 cycle: gap-out after 2 ticks, served in G2
    addn(3, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 0, 0, 3, 4'b0000);
    addn(5, 1, 0, 0, 4, 4'b0000);
    addn(3, 1, 0, 0, 5, 4'b0000);
    addn(1, 1, 0, 0, 0, 4'b0000);
    addn(1, 1, 0, 0, 1, 4'b0000);
    addn(1, 1, 0, 1, 1, 4'b0000);
    addn(3, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 0, 0, 3, 4'b0000);
    addn(1, 1, 0, 0, 4, 4'b0101);
    addn(4, 1, 0, 0, 4, 4'b0100);
    addn(3, 1, 0, 0, 5, 4'b0000);
    // road 1 request held across G1 entry: served now and re-latched
    addn(1, 1, 0, 0, 0, 4'b0000);
    addn(1, 1, 1, 0, 1, 4'b1010);
    addn(2, 1, 1, 0, 1, 4'b1000);
    addn(2, 1, 0, 0, 1, 4'b1000);
    addn(3, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 0, 0, 3, 4'b0000);
    addn(1, 1, 0, 0, 4, 4'b0000);
    addn(1, 1, 0, 0, 4, 4'b0000);
    addn(3, 1, 0, 0, 5, 4'b0000);
    addn(1, 1, 0, 0, 0, 4'b0000);
    addn(1, 1, 0, 0, 1, 4'b1010);
    addn(4, 1, 0, 0, 1, 4'b1000);
    // both requests in Y1: each served at its own green
    addn(1, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 1, 1, 2, 4'b0000);
    addn(1, 1, 0, 0, 2, 4'b0000);
    addn(1, 1, 0, 0, 3, 4'b0000);
    addn(1, 1, 0, 0, 4, 4'b0101);
    addn(1, 1, 0, 0, 4, 4'b0100);
    addn(3, 1, 0, 0, 5, 4'b0000);
    addn(1, 1, 0, 0, 0, 4'b0000);
    addn(1, 1, 0, 0, 1, 4'b1010);
    addn(4, 1, 0, 0, 1, 4'b1000);
    addn(1, 1, 0, 0, 2, 4'b0000);

    foreach (vecs[i]) begin
      TICK     = vecs[i].tick;
      PED_REQ1 = vecs[i].req1;
      PED_REQ2 = vecs[i].req2;
      e.ph     = vecs[i].ph;
      e.lamps  = lamps_for(vecs[i].ph);
      e.ped    = vecs[i].ped;
      sb.push_back(e);
      @(posedge CLK); #1;
      e = sb.pop_front();
      check($sformatf("vec%0d", i), obs(), {e.ph, e.lamps, e.ped});
      check($sformatf("onehot%0d", i),
            {11'b0, $onehot({G1, Y1, R1}), $onehot({G2, Y2, R2})},
            13'b11);
    end
    PED_REQ1 = 1'b0;
    PED_REQ2 = 1'b0;

    // async reset in the middle of Y2
    found = 1'b0;
    TICK  = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge CLK); #1;
      if (PHASE == 3'd5) found = 1'b1;
    end
    check("reach_y2", {12'b0, found}, 13'd1);
    @(posedge CLK); #1;
    check("in_y2", obs(), {3'd5, 6'b001_010, 4'b0});
    #3 RESET = 1'b1;
    #1 check("async_reset", obs(), {3'd0, 6'b001_001, 4'b0});
    #1 RESET = 1'b0;
    @(posedge CLK); #1;
    check("after_reset_g1", obs(), {3'd1, 6'b100_001, 4'b0});

    // TICK every 4th cycle: each phase is 4*DUR cycles
    RESET = 1'b1;
    #1 RESET = 1'b0;
    for (int c = 0; c < 80; c++) begin
      int k;
      TICK = (c % 4 == 0);
      @(posedge CLK); #1;
      k = c / 4 + 1;
      check($sformatf("slow%0d", c), obs(),
            {3'(seq[(k - 1) % 18]), lamps_for(3'(seq[(k - 1) % 18])), 4'b0});
    end

`ifdef FLASH_MODE_EN
    RESET = 1'b1;
    #1 RESET = 1'b0;
    found = 1'b0;
    TICK  = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(posedge CLK); #1;
      if (PHASE == 3'd4) found = 1'b1;
    end
    check("reach_g2", {12'b0, found}, 13'd1);
    FLASH = 1'b1;
    @(posedge CLK); #1;
    check("flash1", obs(), {3'd6, 6'b001_001, 4'b0});
    @(posedge CLK); #1;
    check("flash0", obs(), {3'd6, 6'b000_000, 4'b0});
    @(posedge CLK); #1;
    check("flash1b", obs(), {3'd6, 6'b001_001, 4'b0});
    FLASH = 1'b0;
    @(posedge CLK); #1;
    check("flash_exit", obs(), {3'd0, 6'b001_001, 4'b0});
    @(posedge CLK); #1;
    check("flash_g1", obs(), {3'd1, 6'b100_001, 4'b0});
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
